// File: rtl/fir_pkg.sv
// Shared FIR constants and saturation-limit helpers used by the FIR front and back ends.
package fir_pkg;

  localparam int FIR_ACC_W    = 32;
  localparam int FIR_SAMPLE_W = 16;
  localparam int FIR_Q_SHIFT  = 15;

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with pointer+count bookkeeping and a registered first-word-fall-through head.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_pop     = pop && head_valid;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);

  // NOTE: storage has no reset; only pointers, count and the head register need a defined state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head is a copy of mem[rd_ptr]; refill it from the next slot or from the incoming word.
      if (do_pop)
        head_data <= (count > (AW+1)'(1)) ? mem[rd_ptr + 1'b1] : push_data;
      else if (do_push && !head_valid)
        head_data <= push_data;
    end
  end

endmodule

// File: rtl/fir_decim_requant.sv
// FIR output back end: keep 1 of DECIM samples, round/saturate to OUT_W, buffer in a FWFT FIFO.
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_ACC_W,
  parameter int OUT_W = FIR_SAMPLE_W,
  parameter int SHIFT = FIR_Q_SHIFT,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat_flag,
  output logic                    drop_flag,
  input  logic                    clear_flags
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_R = (IN_W+1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0] MIN_R = (IN_W+1)'(sat_min(OUT_W));

  logic [PH_W-1:0]         ph;
  logic                    keep;
  logic signed [IN_W:0]    sum;
  logic signed [IN_W:0]    r;
  logic signed [OUT_W-1:0] rq_data;
  logic                    rq_sat;
  logic                    s1_valid;
  logic signed [OUT_W-1:0] s1_data;
  logic                    s1_sat;
  logic                    fifo_full;
  logic                    pop;
  logic                    sat_evt;
  logic                    drop_evt;

  assign keep = in_valid && (ph == '0);

  always_ff @(posedge clk) begin
    if (rst)
      ph <= '0;
    else if (in_valid)
      ph <= (ph == PH_W'(DECIM - 1)) ? '0 : ph + 1'b1;
  end

  // NOTE: combinational outputs get a default before any branch so no path leaves them unassigned (no latch).
  always_comb begin
    sum     = $signed({in_data[IN_W-1], in_data}) + HALF;
    r       = sum >>> SHIFT;
    rq_sat  = 1'b0;
    rq_data = r[OUT_W-1:0];
    if (r > MAX_R) begin
      rq_sat  = 1'b1;
      rq_data = OUT_W'(sat_max(OUT_W));
    end else if (r < MIN_R) begin
      rq_sat  = 1'b1;
      rq_data = OUT_W'(sat_min(OUT_W));
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_data <= rq_data;
        s1_sat  <= rq_sat;
      end
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (s1_valid),
    .push_data  (s1_data),
    .pop        (out_ready),
    .head_data  (out_data),
    .head_valid (out_valid),
    .full       (fifo_full)
  );

  assign pop      = out_valid && out_ready;
  assign sat_evt  = s1_valid && s1_sat;
  assign drop_evt = s1_valid && fifo_full && !pop;

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (sat_evt)          sat_flag  <= 1'b1;
      else if (clear_flags) sat_flag  <= 1'b0;
      if (drop_evt)         drop_flag <= 1'b1;
      else if (clear_flags) drop_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_requant.sv
// Self-checking bench: two instances (DECIM=1 and DECIM=4) checked against scoreboard queues.
module tb_fir_decim_requant;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [31:0] in_data;
  logic iv1, iv4, rdy1, rdy4, clr;
  logic ov1, ov4, sat1, sat4, drop1, drop4;
  logic signed [15:0] od1, od4;

  always #5 clk = ~clk;

  fir_decim_requant #(.DECIM(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_data(in_data),
    .out_valid(ov1), .out_ready(rdy1), .out_data(od1),
    .sat_flag(sat1), .drop_flag(drop1), .clear_flags(clr)
  );

  fir_decim_requant #(.DECIM(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_data(in_data),
    .out_valid(ov4), .out_ready(rdy4), .out_data(od4),
    .sat_flag(sat4), .drop_flag(drop4), .clear_flags(clr)
  );

  typedef struct {
    logic signed [31:0] din;
    int                 dout;
  } vec_t;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  vec_t tbl [7];
  exp_t q1 [$];
  exp_t q4 [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ph4      = 0;
  int   sel      = 1;
  bit   lat_chk  = 1'b0;

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int requant(input longint x);
    longint r;
    r = (x + 64'sd16384) >>> 15;
    if (r > 32767)  return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  // Sample outputs mid-cycle; a pop happens at the coming edge when valid && ready.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (ov1 && rdy1) begin
      check("dut1_output_expected", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dut1_data", od1, e.val);
        if (lat_chk) check("dut1_latency", cyc - e.cyc, 2);
      end
    end
    if (ov4 && rdy4) begin
      check("dut4_output_expected", q4.size() > 0, 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("dut4_data", od4, e.val);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic signed [31:0] x, input int exp, input bit want = 1'b1);
    exp_t e;
    e.val   = exp;
    e.cyc   = cyc;
    in_data = x;
    if (sel == 1) begin
      iv1 = 1'b1;
      if (want) q1.push_back(e);
    end else begin
      iv4 = 1'b1;
      if (ph4 == 0 && want) q4.push_back(e);
      ph4 = (ph4 == 3) ? 0 : ph4 + 1;
    end
    tick();
    iv1 = 1'b0;
    iv4 = 1'b0;
  endtask

  task automatic idle(input int n);
    iv1 = 1'b0;
    iv4 = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((q1.size() + q4.size()) != 0 && n < max) begin
      tick();
      n++;
    end
    check("drain_done", q1.size() + q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    in_data = '0;
    iv1 = 1'b0; iv4 = 1'b0; rdy1 = 1'b1; rdy4 = 1'b1; clr = 1'b0;
    tick();
    tick();
    check("rst_out_valid1", ov1, 0);
    check("rst_out_data1", od1, 0);
    check("rst_sat1", sat1, 0);
    check("rst_drop1", drop1, 0);
    check("rst_out_valid4", ov4, 0);
    check("rst_out_data4", od4, 0);
    rst = 1'b0;
    tick();

    tbl[0] = '{din: 32'sd16384,  dout: 1};
    tbl[1] = '{din: 32'sd16383,  dout: 0};
    tbl[2] = '{din: -32'sd16384, dout: 0};
    tbl[3] = '{din: -32'sd16385, dout: -1};
    tbl[4] = '{din: 32'sd49152,  dout: 2};
    tbl[5] = '{din: 32'h7FFF_FFFF, dout: 32767};
    tbl[6] = '{din: 32'h8000_0000, dout: -32768};

    // Rounding, back-to-back with 2-cycle latency check
    sel = 1;
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) send(tbl[i].din, tbl[i].dout);
    drain(10);
    lat_chk = 1'b0;
    check("round_sat_flag", sat1, 0);
    check("round_drop_flag", drop1, 0);

    // Saturation and flag clear
    for (int i = 5; i < 7; i++) send(tbl[i].din, tbl[i].dout);
    drain(10);
    check("sat_flag_set", sat1, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sat_flag_cleared", sat1, 0);

    // Decimation, continuous then gapped
    sel = 4;
    for (int k = 0; k < 12; k++) send(32'(k * 32768), k);
    drain(10);
    for (int k = 0; k < 12; k++) begin
      send(32'(k * 32768), k);
      idle(2);
    end
    drain(10);

    // Backpressure: 6 arrive, 4 fit
    sel = 1;
    rdy1 = 1'b0;
    for (int k = 1; k <= 6; k++) send(32'(k * 32768), k, k <= 4);
    idle(3);
    check("bp_out_valid", ov1, 1);
    check("bp_head", od1, 1);
    check("bp_drop_flag", drop1, 1);
    rdy1 = 1'b1;
    drain(10);
    check("bp_drained_empty", ov1, 0);

    // Full FIFO with push and pop in the same cycle
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("drop_flag_cleared", drop1, 0);
    rdy1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) rdy1 = 1'b1;
      send(32'((20 + i) * 32768), 20 + i);
    end
    drain(10);
    check("full_pushpop_no_drop", drop1, 0);

    // Reset with 3 words in FIFO, S1 valid, phase non-zero
    sel = 4;
    rdy4 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      in_data = (i == 0) ? 32'h7FFF_FFFF : 32'(i * 32768);
      send(in_data, requant(longint'(in_data)));
    end
    check("pre_rst_out_valid4", ov4, 1);
    check("pre_rst_sat4", sat4, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q1.delete();
    q4.delete();
    ph4 = 0;
    check("midrst_out_valid4", ov4, 0);
    check("midrst_sat4", sat4, 0);
    check("midrst_drop4", drop4, 0);
    check("midrst_out_valid1", ov1, 0);
    rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) send(32'((5 + i) * 32768), 5 + i);
    drain(10);

    idle(4);
    check("final_out_valid1", ov1, 0);
    check("final_out_valid4", ov4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
